pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: CLK and nRST.
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  synchronous active-low reset.
- ihit  in  1  instruction fetch completes this cycle.
- dhit  in  1  data access completes this cycle.
- em_mem_req  in  1  instruction in EM is a load or store (dcuREN|dcuWEN).
- de_load  in  1  instruction in DE is a load (dcuREN).
- de_rt  in  5  destination register of the DE load.
- fd_rs  in  5  rs field of the instruction in FD.
- fd_rt  in  5  rt field of the instruction in FD.
- fd_uses_rs  in  1  FD instruction reads rs.
- fd_uses_rt  in  1  FD instruction reads rt.
- ex_redirect  in  1  branch mispredict or jump resolved in EX; PC mux selects the target.
- mw_halt  in  1  MW latch holds a halt.
- pc_en  out  1  PC register load enable.
- fd_en, de_en, em_en, mw_en  out  1 each  latch enables.
- fd_flush, de_flush  out  1 each  load a bubble into the latch when its enable is 1.
- halted  out  1  processor halted.
- stall_cnt  out  16  saturating count of stall cycles.
- flush_cnt  out  16  saturating count of accepted redirects.

Function
REQ-003 The FSM SHALL have the states RUN, MEMWAIT and HALTED, and an ihit_pend flag.
REQ-004 ifetch SHALL be defined as ihit | ihit_pend.
REQ-005 dfreeze SHALL be defined as em_mem_req & ~dhit.
REQ-006 A load-use hazard (lu) SHALL be defined as de_load & (de_rt!=0) & ((fd_uses_rs & fd_rs==de_rt) | (fd_uses_rt & fd_rt==de_rt)).
REQ-007 In HALTED, all enables and flushes SHALL be 0, halted SHALL be 1, and the state SHALL stay HALTED until reset.
REQ-008 In RUN or MEMWAIT with dfreeze=1, all enables and flushes SHALL be 0; next state MEMWAIT.
REQ-009 In RUN or MEMWAIT with dfreeze=0, em_en=mw_en=1 and de_en=1; next state RUN.
- Priority 1: ex_redirect=1 -> pc_en=1, fd_en=1, fd_flush=1, de_flush=1, regardless of ifetch and lu.
- Priority 2: lu=1 -> pc_en=0, fd_en=0, de_flush=1.
- Priority 3: ifetch=0 -> pc_en=0, fd_en=1, fd_flush=1.
- Otherwise: pc_en=fd_en=1, no flush.
REQ-010 ihit_pend SHALL set when ihit=1 and pc_en=0.
REQ-011 ihit_pend SHALL clear on any cycle with pc_en=1; set has no effect in that cycle.
REQ-012 When mw_halt=1 and mw_en=1, the next state SHALL be HALTED; this overrides all other transitions.
REQ-013 stall_cnt SHALL increment by 1 on each non-HALTED cycle with pc_en=0 and saturate at 16'hFFFF.
REQ-014 flush_cnt SHALL increment on each cycle where ex_redirect=1 and em_en=1, and saturate at 16'hFFFF.
REQ-015 All outputs SHALL be pure functions of current state and inputs; there is no added latency.

Reset
REQ-016 While nRST=0 at a rising edge, the following SHALL take effect at that edge, including mid-MEMWAIT or HALTED: state=RUN, ihit_pend=0, stall_cnt=0, flush_cnt=0.
REQ-017 While nRST=0, all enables, flushes and halted SHALL be forced to 0 combinationally.

Verification
REQ-018 Load-use: de_load=1, de_rt=5, fd_rs=5, fd_uses_rs=1, ihit=1 -> pc_en=0, fd_en=0, de_flush=1, em_en=1; stall_cnt +1.
REQ-019 Dmem wait: em_mem_req=1, dhit=0 for 3 cycles then dhit=1, with ihit=1 on the 2nd cycle -> all enables 0 for 3 cycles in MEMWAIT; on the dhit cycle, pc_en=1 via ihit_pend, which then clears.
REQ-020 Redirect and lu together: ex_redirect=1 with lu=1 and ihit=0 -> pc_en=1, fd_flush=de_flush=1, flush_cnt +1.
REQ-021 Halt: mw_halt=1, no dfreeze -> next cycle halted=1 with all enables 0; stays halted for 10 cycles of arbitrary inputs; nRST=0 for one edge -> RUN, counters 0.
REQ-022 Saturation: force 70000 consecutive ifetch=0 cycles -> stall_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller for a 5-stage pipeline: decides latch enables, bubbles,
// PC advance and halt, and keeps saturating stall/redirect counters.
module pipeline_ctrl (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ihit,
   input  logic        dhit,
   input  logic        em_mem_req,
   input  logic        de_load,
   input  logic [4:0]  de_rt,
   input  logic [4:0]  fd_rs,
   input  logic [4:0]  fd_rt,
   input  logic        fd_uses_rs,
   input  logic        fd_uses_rt,
   input  logic        ex_redirect,
   input  logic        mw_halt,
   output logic        pc_en,
   output logic        fd_en,
   output logic        de_en,
   output logic        em_en,
   output logic        mw_en,
   output logic        fd_flush,
   output logic        de_flush,
   output logic        halted,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt
);

   typedef enum logic [1:0] {RUN, MEMWAIT, HALTED} state_t;

   state_t state;
   logic   ihit_pend;
   logic   ifetch;
   logic   dfreeze;
   logic   lu;

   assign ifetch  = ihit | ihit_pend;
   assign dfreeze = em_mem_req & ~dhit;
   assign lu      = de_load & (de_rt != 5'd0) &
                    ((fd_uses_rs & (fd_rs == de_rt)) | (fd_uses_rt & (fd_rt == de_rt)));

   // Outputs are combinational so a hazard takes effect in the cycle it is seen.
   always_comb begin
      pc_en    = 1'b0;
      fd_en    = 1'b0;
      de_en    = 1'b0;
      em_en    = 1'b0;
      mw_en    = 1'b0;
      fd_flush = 1'b0;
      de_flush = 1'b0;
      halted   = 1'b0;
      if (nRST) begin
         if (state == HALTED) begin
            halted = 1'b1;
         end else if (!dfreeze) begin
            de_en = 1'b1;
            em_en = 1'b1;
            mw_en = 1'b1;
            if (ex_redirect) begin
               pc_en    = 1'b1;
               fd_en    = 1'b1;
               fd_flush = 1'b1;
               de_flush = 1'b1;
            end else if (lu) begin
               de_flush = 1'b1;
            end else if (!ifetch) begin
               fd_en    = 1'b1;
               fd_flush = 1'b1;
            end else begin
               pc_en = 1'b1;
               fd_en = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state     <= RUN;
         ihit_pend <= 1'b0;
         stall_cnt <= 16'd0;
         flush_cnt <= 16'd0;
      end else begin
         if (state != HALTED) begin
            if (mw_halt && mw_en)
               state <= HALTED;
            else if (dfreeze)
               state <= MEMWAIT;
            else
               state <= RUN;
         end
         // Remember an instruction that arrived while the PC was held.
         if (pc_en)
            ihit_pend <= 1'b0;
         else if (ihit)
            ihit_pend <= 1'b1;
         if ((state != HALTED) && !pc_en && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
         if (ex_redirect && em_en && (flush_cnt != 16'hFFFF))
            flush_cnt <= flush_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed hazard scenarios plus random traffic,
// checked against a rule-level reference model.
module tb_pipeline_ctrl;

   typedef struct packed {
      logic       nrst;
      logic       ihit;
      logic       dhit;
      logic       em_mem_req;
      logic       de_load;
      logic [4:0] de_rt;
      logic [4:0] fd_rs;
      logic [4:0] fd_rt;
      logic       fd_uses_rs;
      logic       fd_uses_rt;
      logic       ex_redirect;
      logic       mw_halt;
   } stim_t;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        ihit, dhit, em_mem_req, de_load, fd_uses_rs, fd_uses_rt, ex_redirect, mw_halt;
   logic [4:0]  de_rt, fd_rs, fd_rt;
   logic        pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, halted;
   logic [15:0] stall_cnt, flush_cnt;

   pipeline_ctrl dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .em_mem_req(em_mem_req),
      .de_load(de_load), .de_rt(de_rt), .fd_rs(fd_rs), .fd_rt(fd_rt),
      .fd_uses_rs(fd_uses_rs), .fd_uses_rt(fd_uses_rt), .ex_redirect(ex_redirect),
      .mw_halt(mw_halt), .pc_en(pc_en), .fd_en(fd_en), .de_en(de_en), .em_en(em_en),
      .mw_en(mw_en), .fd_flush(fd_flush), .de_flush(de_flush), .halted(halted),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   // clock / reset
   always #5 CLK = ~CLK;

   // scoreboard state
   logic [39:0] exp_q[$];
   string       tag_q[$];
   int          tests = 0;
   int          fails = 0;

   // reference model state
   bit m_halted = 0;
   bit m_pend   = 0;
   int m_stall  = 0;
   int m_flush  = 0;

   function automatic stim_t idle_stim();
      stim_t s;
      s = '0;
      s.nrst = 1'b1;
      s.dhit = 1'b1;
      return s;
   endfunction

   function automatic stim_t rand_stim();
      stim_t s;
      s.nrst        = ($urandom_range(0, 63) != 0);
      s.ihit        = $urandom_range(0, 1);
      s.dhit        = ($urandom_range(0, 2) != 0);
      s.em_mem_req  = $urandom_range(0, 1);
      s.de_load     = $urandom_range(0, 1);
      s.de_rt       = 5'($urandom_range(0, 3));
      s.fd_rs       = 5'($urandom_range(0, 3));
      s.fd_rt       = 5'($urandom_range(0, 3));
      s.fd_uses_rs  = $urandom_range(0, 1);
      s.fd_uses_rt  = $urandom_range(0, 1);
      s.ex_redirect = ($urandom_range(0, 3) == 0);
      s.mw_halt     = ($urandom_range(0, 40) == 0);
      return s;
   endfunction

   // Reference model: outputs for this cycle, then advance model state over the edge.
   task automatic model_step(input stim_t s, output logic [39:0] e);
      bit fetch_ok, frozen, hazard;
      bit pc, fd, de, em, mw, ff, df, h;
      fetch_ok = s.ihit || m_pend;
      frozen   = s.em_mem_req && !s.dhit;
      hazard   = s.de_load && (s.de_rt != 0) &&
                 ((s.fd_uses_rs && s.fd_rs == s.de_rt) || (s.fd_uses_rt && s.fd_rt == s.de_rt));
      {pc, fd, de, em, mw, ff, df, h} = '0;
      if (s.nrst) begin
         if (m_halted) h = 1;
         else if (!frozen) begin
            {de, em, mw} = 3'b111;
            if (s.ex_redirect) {pc, fd, ff, df} = 4'b1111;
            else if (hazard) df = 1;
            else if (!fetch_ok) {fd, ff} = 2'b11;
            else {pc, fd} = 2'b11;
         end
      end
      e = {pc, fd, de, em, mw, ff, df, h, m_stall[15:0], m_flush[15:0]};
      if (!s.nrst) begin
         m_halted = 0; m_pend = 0; m_stall = 0; m_flush = 0;
      end else begin
         if (!m_halted && !pc && m_stall < 65535) m_stall++;
         if (s.ex_redirect && em && m_flush < 65535) m_flush++;
         if (pc) m_pend = 0;
         else if (s.ihit) m_pend = 1;
         if (s.mw_halt && mw) m_halted = 1;
      end
   endtask

   // driver: apply one cycle of stimulus and post the expected response
   task automatic drive(input stim_t s, input string tag);
      logic [39:0] e;
      @(negedge CLK);
      nRST = s.nrst; ihit = s.ihit; dhit = s.dhit; em_mem_req = s.em_mem_req;
      de_load = s.de_load; de_rt = s.de_rt; fd_rs = s.fd_rs; fd_rt = s.fd_rt;
      fd_uses_rs = s.fd_uses_rs; fd_uses_rt = s.fd_uses_rt;
      ex_redirect = s.ex_redirect; mw_halt = s.mw_halt;
      #1;
      model_step(s, e);
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   // monitor: outputs are valid every cycle, sampled mid-low-phase
   initial begin
      logic [39:0] got, e;
      string tag;
      forever begin
         @(negedge CLK);
         #2;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            tag = tag_q.pop_front();
            got = {pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, halted, stall_cnt, flush_cnt};
            tests++;
            if (got !== e) begin
               fails++;
               $display("FAIL %s @%0t: got en/fl/h=%b stall=%h flush=%h, want en/fl/h=%b stall=%h flush=%h",
                        tag, $time, got[39:32], got[31:16], got[15:0], e[39:32], e[31:16], e[15:0]);
            end
         end
      end
   end

   initial begin
      stim_t s;
      {ihit, dhit, em_mem_req, de_load, fd_uses_rs, fd_uses_rt, ex_redirect, mw_halt} = '0;
      {de_rt, fd_rs, fd_rt} = '0;
      nRST = 1'b0;
      repeat (3) @(posedge CLK);

      // reset state and idle cycles (no fetch -> bubble into FD)
      s = idle_stim();
      drive(s, "reset_state");
      s.ihit = 1; drive(s, "idle_fetch");

      // load-use hazard
      s = idle_stim(); s.ihit = 1; s.de_load = 1; s.de_rt = 5; s.fd_rs = 5; s.fd_uses_rs = 1;
      drive(s, "load_use");
      s = idle_stim(); s.ihit = 1; drive(s, "load_use_after");
      // load to r0 is not a hazard
      s = idle_stim(); s.ihit = 1; s.de_load = 1; s.fd_rs = 0; s.fd_uses_rs = 1;
      drive(s, "load_r0");
      // rt match but rt unused
      s = idle_stim(); s.ihit = 1; s.de_load = 1; s.de_rt = 7; s.fd_rt = 7;
      drive(s, "rt_unused");

      // dmem wait with ifetch arriving mid-freeze
      s = idle_stim(); s.em_mem_req = 1; s.dhit = 0;
      drive(s, "memwait_1");
      s.ihit = 1; drive(s, "memwait_2");
      s.ihit = 0; drive(s, "memwait_3");
      s.dhit = 1; drive(s, "memwait_release");
      s = idle_stim(); drive(s, "pend_cleared");

      // redirect overrides load-use with no fetch
      s = idle_stim(); s.ex_redirect = 1; s.de_load = 1; s.de_rt = 3; s.fd_rt = 3; s.fd_uses_rt = 1;
      drive(s, "redirect_lu");
      s = idle_stim(); s.ihit = 1; drive(s, "after_redirect");
      // redirect during dfreeze is not accepted
      s = idle_stim(); s.ex_redirect = 1; s.em_mem_req = 1; s.dhit = 0;
      drive(s, "redirect_frozen");

      // halt, stay halted under random inputs, then reset out
      s = idle_stim(); s.ihit = 1; s.mw_halt = 1; drive(s, "halt_enter");
      for (int i = 0; i < 10; i++) begin
         s = rand_stim(); s.nrst = 1; drive(s, "halted_hold");
      end
      s = idle_stim(); s.nrst = 0; drive(s, "halt_reset");
      s = idle_stim(); s.ihit = 1; drive(s, "post_reset");

      // halt requested during dfreeze is ignored
      s = idle_stim(); s.mw_halt = 1; s.em_mem_req = 1; s.dhit = 0; drive(s, "halt_frozen");
      s = idle_stim(); s.ihit = 1; drive(s, "halt_frozen_after");

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         s = rand_stim(); drive(s, "random");
      end

      // stall counter saturation
      s = idle_stim(); s.nrst = 0; drive(s, "sat_reset");
      s = idle_stim();
      for (int i = 0; i < 70000; i++) drive(s, "stall_sat");
      s.ex_redirect = 1; drive(s, "sat_hold_redirect");

      // drain the scoreboard within a bounded number of cycles
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge CLK);
      #3;
      if (exp_q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain: %0d responses left, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
